// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI monarch and its SCLK generator.
package spi_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    BACK  = 2'd2
  } spi_state_t;

  // Mode 3: SCLK idles high.
  localparam logic SCLK_IDLE = 1'b1;

  // Width of a serf-select index; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: free-running up counter whose MSB is SCLK, plus one-cycle
// early flags for the clk edge on which SCLK will rise or fall.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int SCLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic preload,
  output logic SCLK,
  output logic rise_imm,
  output logic fall_imm
);

  localparam int CW = $clog2(SCLK_DIV);
  localparam logic [CW-1:0] IDLE_CNT = {CW{SCLK_IDLE}};
  localparam logic [CW-1:0] RISE_CNT = CW'(SCLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FALL_CNT = CW'(SCLK_DIV - 1);
  // The accepting edge counts as the first divider tick after the
  // 3/4-period preload point, so the counter lands one count past it.
  // This puts the first SCLK fall a quarter period after accept.
  localparam logic [CW-1:0] LOAD_CNT = CW'(3 * SCLK_DIV / 4);

  logic [CW-1:0] cnt_reg;

  // Divider counter: preload on accept, count while running, park at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= IDLE_CNT;
    end else if (preload) begin
      cnt_reg <= LOAD_CNT;
    end else if (run) begin
      cnt_reg <= cnt_reg + CW'(1);
    end else begin
      cnt_reg <= IDLE_CNT;
    end
  end

  assign SCLK     = cnt_reg[CW-1];
  assign rise_imm = (cnt_reg == RISE_CNT);
  assign fall_imm = (cnt_reg == FALL_CNT);

endmodule

// File: rtl/spi_mnrch_gen.sv
// Parametrised SPI mode-3 monarch with multiple serf selects and a hold
// mode that keeps the select low across back-to-back frames.
module spi_mnrch_gen
  import spi_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int SCLK_DIV = 16,
  parameter int NUM_SS   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wrt,
  input  logic [DATA_W-1:0]            wt_data,
  input  logic [sel_width(NUM_SS)-1:0] ss_sel,
  input  logic                         hold,
  input  logic                         MISO,
  output logic                         SCLK,
  output logic                         MOSI,
  output logic [NUM_SS-1:0]            SS_n,
  output logic                         busy,
  output logic                         done,
  output logic [DATA_W-1:0]            rd_data
);

  localparam int SEL_W = sel_width(NUM_SS);
  localparam int BW    = $clog2(DATA_W + 1);

  spi_state_t        state_reg, state_next;
  logic [DATA_W-1:0] shift_reg;
  logic              miso_smp_reg;
  logic [BW-1:0]     bit_cnt_reg;
  logic              hold_reg;
  logic [NUM_SS-1:0] ss_n_reg;
  logic              done_reg;

  logic              accept;
  logic              run, preload, smp_en, shift_en, finish;
  logic              rise_imm, fall_imm;
  logic [NUM_SS-1:0] sel_dec;

  // One-hot decode of the requested serf index.
  for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_sel_dec
    assign sel_dec[gi] = (ss_sel == SEL_W'(gi));
  end

  // A request is taken only when idle and aimed at an existing serf.
  assign accept = (state_reg == IDLE) && wrt && (int'(ss_sel) < NUM_SS);

  spi_sclk_gen #(
    .SCLK_DIV(SCLK_DIV)
  ) u_sclk_gen (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .preload (preload),
    .SCLK    (SCLK),
    .rise_imm(rise_imm),
    .fall_imm(fall_imm)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and strobe decode; the divider is stopped on the closing
  // fall point so SCLK stays high instead of falling.
  always_comb begin
    state_next = state_reg;
    run        = 1'b0;
    preload    = 1'b0;
    smp_en     = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          preload    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        run = 1'b1;
        if (rise_imm) begin
          smp_en = 1'b1;
          if (bit_cnt_reg == BW'(DATA_W - 1)) state_next = BACK;
        end
        // The first fall only launches MOSI; nothing has been sampled yet.
        if (fall_imm && (bit_cnt_reg != '0)) shift_en = 1'b1;
      end
      BACK: begin
        if (fall_imm) begin
          shift_en   = 1'b1;
          finish     = 1'b1;
          state_next = IDLE;
        end else begin
          run = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load, sample, shift, selects and completion flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg    <= '0;
      miso_smp_reg <= 1'b0;
      bit_cnt_reg  <= '0;
      hold_reg     <= 1'b0;
      ss_n_reg     <= '1;
      done_reg     <= 1'b0;
    end else begin
      if (accept) begin
        shift_reg   <= wt_data;
        bit_cnt_reg <= '0;
        hold_reg    <= hold;
        done_reg    <= 1'b0;
        // Also releases any line still held from a previous burst.
        ss_n_reg    <= ~sel_dec;
      end
      if (smp_en) begin
        miso_smp_reg <= MISO;
        bit_cnt_reg  <= bit_cnt_reg + BW'(1);
      end
      if (shift_en) shift_reg <= {shift_reg[DATA_W-2:0], miso_smp_reg};
      if (finish) begin
        done_reg <= 1'b1;
        if (!hold_reg) ss_n_reg <= '1;
      end
    end
  end

  assign MOSI    = shift_reg[DATA_W-1];
  assign SS_n    = ss_n_reg;
  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign rd_data = shift_reg;

endmodule

// File: doc/spi_mnrch_gen.md
# spi_mnrch_gen

Parametrised SPI monarch, the next generation of the single-slave 16-bit `SPI_mnrch`. It drives SPI mode 3 (SCLK idles high, MOSI changes on SCLK fall, MISO sampled on SCLK rise). It is generalised in frame width, SCLK divide ratio and serf-select count. It adds a burst/hold mode that keeps SS_n asserted across back-to-back frames for multi-byte register reads from the inertial sensor and future SPI peripherals.

## Interface
- DATA_W, 16, frame width in bits; legal 8..32.
- SCLK_DIV, 16, clk cycles per SCLK period; power of 2, >= 8.
- NUM_SS, 1, number of serf-select lines; 1..8.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high; one clock domain.
- wrt  in  1  start a frame; sampled only when busy=0.
- wt_data  in  DATA_W  frame to send, MSB first.
- ss_sel  in  max(1,$clog2(NUM_SS))  serf index for this frame; captured with wrt.
- hold  in  1  captured with wrt; 1 = keep SS_n low after this frame.
- MISO  in  1  serial data from serf.
- SCLK  out  1  serial clock.
- MOSI  out  1  serial data to serf; always equals shift-register MSB.
- SS_n  out  NUM_SS  active-low selects; at most one bit low.
- busy  out  1  frame in progress.
- done  out  1  level; set at frame end, cleared by the next accepted wrt.
- rd_data  out  DATA_W  full-duplex received frame; valid while done=1.

## Operation
- States: IDLE, SHIFT, BACK.
- IDLE:
  - wrt=1 -> load shift register with wt_data, capture ss_sel/hold, preload divider to 3*SCLK_DIV/4-1, clear done, set busy, drive SS_n[ss_sel] low, go SHIFT.
  - wrt with ss_sel out of range (>= NUM_SS) -> ignored.
- Divider: log2(SCLK_DIV)-bit up counter, free-running in SHIFT/BACK, held at all-ones in IDLE. SCLK = counter MSB.
  - Rise point: count = SCLK_DIV/2-1.
  - Fall point: count = SCLK_DIV-1.
- SHIFT:
  - At each rise point: MISO is sampled into a holding bit and the bit counter increments.
  - At each fall point except the first: the shift register shifts left, inserting the sampled bit.
  - After the DATA_W-th sample -> BACK.
- BACK:
  - At the next fall point the final shift occurs and SCLK is forced high (no fall).
  - Then done=1, busy=0, state -> IDLE.
  - If captured hold=0, SS_n goes all-ones on the same edge.
- Hold:
  - If captured hold=1, the selected SS_n stays low after done.
  - A following wrt to the same ss_sel continues the burst without SS_n toggling.
  - A wrt to a different ss_sel raises the held line and lowers the new line on the same edge.
  - A wrt with hold=0 ends the burst after that frame.
- wrt while busy=1: ignored, no effect on any state.
- rst (any state): state IDLE, counters cleared, hold flag cleared.

## Timing
- Reset values: SCLK=1, SS_n=all ones, MOSI=0, busy=0, done=0, rd_data=0.
- busy and SS_n change on the edge that accepts wrt.
- First SCLK fall occurs SCLK_DIV/4 clks after accept; MOSI is valid SCLK_DIV/4 clks before the first fall.
- done rises DATA_W*SCLK_DIV + SCLK_DIV/4 clks after the accepting edge. Defaults: 260 clks.
- SS_n deasserts on the done edge. SCLK is high for >= SCLK_DIV/4 clks before SS_n rises.
- A wrt in the same cycle that done rises is not accepted, because busy is still 1. The earliest next accept is the cycle after done.
- rd_data is stable from done until the next accepted wrt.

## Structure
- Package `spi_pkg`: state enum (IDLE, SHIFT, BACK), function for the select width max(1,$clog2(n)), mode-3 polarity constant.
- Sub-module `spi_sclk_gen`, parametrised on SCLK_DIV:
  - Inputs: clk, rst, run, preload.
  - Outputs: SCLK, rise_imm, fall_imm.
- All else lives in the top level.

## Test plan
- Defaults with SPI_iNEMO1 serf: wt_data=16'h8F00 -> done after 260 clks; rd_data[7:0]=8'h6A; SS_n high after done.
- Write 16'h0D02, then wait for INT -> iNEMO.NEMO_setup=1; INT rises within 100000 clks. Then read 16'hA500 -> rd_data[7:0]=8'h7B.
- Burst: wrt 16'hA400 with hold=1, then wrt 16'hA500 with hold=0 -> SS_n[0] stays low across both frames. rd_data[7:0]=8'h0D then 8'h7B. SS_n rises after the second done.
- DATA_W=8, SCLK_DIV=8, loopback (MOSI tied to MISO), wt_data=8'hA5 -> rd_data=8'hA5. done exactly 66 clks after accept. Exactly 8 SCLK rises.
- NUM_SS=4:
  - ss_sel=2 -> only SS_n[2] low during the frame.
  - Hold on 2, then wrt ss_sel=3 -> SS_n[2] rises and SS_n[3] falls on the same edge.
- Assert rst mid-frame (bit 5) -> the next clk shows SCLK=1, SS_n=all ones, busy=0, done=0. A subsequent WHO_AM_I read returns 8'h6A.
